// File: rtl/commande_boutons.sv
// Button conditioning for the brick-stack counter: synchronise, debounce, arm and
// edge-detect both push-buttons, then arbitrate into clean plus/moins/conflit pulses.
module commande_boutons #(
  parameter int N_STABLE      = 4,
  parameter int CNT_W         = 20,
  parameter int REPEAT_PERIOD = 0,
  parameter int REP_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_plus,
  input  logic btn_moins,
  output logic plus,
  output logic moins,
  output logic conflit
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_P  = 2'd1,
    HOLD_M  = 2'd2,
    BLOCKED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(N_STABLE - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'((REPEAT_PERIOD > 0) ? (REPEAT_PERIOD - 1) : 0);

  logic             r_s1_p, r_s2_p, r_d_p, r_dq_p, r_armed_p;
  logic             r_s1_m, r_s2_m, r_d_m, r_dq_m, r_armed_m;
  logic [CNT_W-1:0] r_cnt_p, r_cnt_m;
  logic [1:0]       r_fill;
  logic [REP_W-1:0] r_rep;
  state_t           r_state;

  logic             w_rise_p, w_rise_m, w_press_p, w_press_m;
  state_t           w_state_nxt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_plus_nxt, w_moins_nxt, w_conflit_nxt;

  assign w_rise_p  = r_d_p & ~r_dq_p;
  assign w_rise_m  = r_d_m & ~r_dq_m;
  assign w_press_p = w_rise_p & r_armed_p;
  assign w_press_m = w_rise_m & r_armed_m;

  // Synchronisers, debounce filters and arming. r_fill marks when s2 carries a
  // real button sample rather than its reset value, so a button held through
  // reset cannot arm itself on the first cycles after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_p    <= 1'b0;
      r_s2_p    <= 1'b0;
      r_d_p     <= 1'b0;
      r_dq_p    <= 1'b0;
      r_armed_p <= 1'b0;
      r_cnt_p   <= {CNT_W{1'b0}};
      r_s1_m    <= 1'b0;
      r_s2_m    <= 1'b0;
      r_d_m     <= 1'b0;
      r_dq_m    <= 1'b0;
      r_armed_m <= 1'b0;
      r_cnt_m   <= {CNT_W{1'b0}};
      r_fill    <= 2'b00;
    end else begin
      r_s1_p <= btn_plus;
      r_s2_p <= r_s1_p;
      r_s1_m <= btn_moins;
      r_s2_m <= r_s1_m;
      r_dq_p <= r_d_p;
      r_dq_m <= r_d_m;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_s2_p) r_armed_p <= 1'b1;
      if (r_fill[1] && !r_s2_m) r_armed_m <= 1'b1;

      if (r_s2_p == r_d_p) begin
        r_cnt_p <= {CNT_W{1'b0}};
      end else if (r_cnt_p == DB_LAST) begin
        r_d_p   <= r_s2_p;
        r_cnt_p <= {CNT_W{1'b0}};
      end else begin
        r_cnt_p <= r_cnt_p + CNT_W'(1);
      end

      if (r_s2_m == r_d_m) begin
        r_cnt_m <= {CNT_W{1'b0}};
      end else if (r_cnt_m == DB_LAST) begin
        r_d_m   <= r_s2_m;
        r_cnt_m <= {CNT_W{1'b0}};
      end else begin
        r_cnt_m <= r_cnt_m + CNT_W'(1);
      end
    end
  end

  // Arbitration FSM: next state, repeat counter and pulse requests.
  always_comb begin
    w_state_nxt   = r_state;
    w_rep_nxt     = r_rep;
    w_plus_nxt    = 1'b0;
    w_moins_nxt   = 1'b0;
    w_conflit_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_p && w_press_m) begin
          w_conflit_nxt = 1'b1;
          w_state_nxt   = BLOCKED;
        end else if (w_press_p) begin
          w_plus_nxt  = 1'b1;
          w_rep_nxt   = {REP_W{1'b0}};
          w_state_nxt = HOLD_P;
        end else if (w_press_m) begin
          w_moins_nxt = 1'b1;
          w_rep_nxt   = {REP_W{1'b0}};
          w_state_nxt = HOLD_M;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HOLD_P: begin
        if (w_rise_m) begin
          w_conflit_nxt = 1'b1;
          w_state_nxt   = BLOCKED;
        end else if (!r_d_p) begin
          w_state_nxt = IDLE;
        end else if (REPEAT_PERIOD != 0) begin
          if (r_rep == REP_LAST) begin
            w_plus_nxt = 1'b1;
            w_rep_nxt  = {REP_W{1'b0}};
          end else begin
            w_rep_nxt = r_rep + REP_W'(1);
          end
        end else begin
          w_rep_nxt = r_rep;
        end
      end
      HOLD_M: begin
        if (w_rise_p) begin
          w_conflit_nxt = 1'b1;
          w_state_nxt   = BLOCKED;
        end else if (!r_d_m) begin
          w_state_nxt = IDLE;
        end else if (REPEAT_PERIOD != 0) begin
          if (r_rep == REP_LAST) begin
            w_moins_nxt = 1'b1;
            w_rep_nxt   = {REP_W{1'b0}};
          end else begin
            w_rep_nxt = r_rep + REP_W'(1);
          end
        end else begin
          w_rep_nxt = r_rep;
        end
      end
      BLOCKED: begin
        if (!r_d_p && !r_d_m) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BLOCKED;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, repeat counter and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rep   <= {REP_W{1'b0}};
      plus    <= 1'b0;
      moins   <= 1'b0;
      conflit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rep   <= w_rep_nxt;
      plus    <= w_plus_nxt;
      moins   <= w_moins_nxt;
      conflit <= w_conflit_nxt;
    end
  end

endmodule

// File: tb/tb_commande_boutons.sv
// Self-checking bench for commande_boutons: a table of button windows with
// expected pulse counts, plus hand-written latency, reset and auto-repeat sequences.
module tb_commande_boutons;

  logic clk = 1'b0;
  logic reset, btn_plus, btn_moins;
  logic plus, moins, conflit;
  logic plus_r, moins_r, conflit_r;
  int   checks = 0;
  int   errors = 0;
  int   excl_viol = 0;

  always #5 clk = ~clk;

  commande_boutons #(.N_STABLE(4), .CNT_W(20), .REPEAT_PERIOD(0), .REP_W(24)) dut (
    .clk(clk), .reset(reset), .btn_plus(btn_plus), .btn_moins(btn_moins),
    .plus(plus), .moins(moins), .conflit(conflit));

  commande_boutons #(.N_STABLE(4), .CNT_W(20), .REPEAT_PERIOD(8), .REP_W(24)) dut_r (
    .clk(clk), .reset(reset), .btn_plus(btn_plus), .btn_moins(btn_moins),
    .plus(plus_r), .moins(moins_r), .conflit(conflit_r));

  typedef struct {
    logic  p;
    logic  m;
    int    cycles;
    int    np;
    int    nm;
    int    nc;
    string name;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling 1 ns after each rising edge, and count pulses.
  task automatic run_window(input int n, output int np, output int nm, output int nc);
    np = 0; nm = 0; nc = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      np += int'(plus);
      nm += int'(moins);
      nc += int'(conflit);
      if ((int'(plus) + int'(moins) + int'(conflit)) > 1) excl_viol++;
      if ((int'(plus_r) + int'(moins_r) + int'(conflit_r)) > 1) excl_viol++;
    end
  endtask

  initial begin
    int np, nm, nc, npr;

    vecs[0]  = '{1'b0, 1'b0, 12, 0, 0, 0, "release_after_latency"};
    vecs[1]  = '{1'b0, 1'b1, 20, 0, 1, 0, "moins_press1"};
    vecs[2]  = '{1'b0, 1'b0, 12, 0, 0, 0, "moins_release1"};
    vecs[3]  = '{1'b0, 1'b1, 20, 0, 1, 0, "moins_press2"};
    vecs[4]  = '{1'b0, 1'b0, 12, 0, 0, 0, "moins_release2"};
    vecs[5]  = '{1'b1, 1'b0,  2, 0, 0, 0, "glitch_hi1"};
    vecs[6]  = '{1'b0, 1'b0,  2, 0, 0, 0, "glitch_lo1"};
    vecs[7]  = '{1'b1, 1'b0,  2, 0, 0, 0, "glitch_hi2"};
    vecs[8]  = '{1'b0, 1'b0, 12, 0, 0, 0, "glitch_settle"};
    vecs[9]  = '{1'b1, 1'b1, 20, 0, 0, 1, "both_same_cycle"};
    vecs[10] = '{1'b1, 1'b0, 20, 0, 0, 0, "blocked_moins_released"};
    vecs[11] = '{1'b0, 1'b0, 12, 0, 0, 0, "blocked_both_released"};
    vecs[12] = '{1'b1, 1'b0, 20, 1, 0, 0, "plus_after_blocked"};
    vecs[13] = '{1'b0, 1'b0, 12, 0, 0, 0, "release_plus"};
    vecs[14] = '{1'b1, 1'b0, 10, 1, 0, 0, "plus_first"};
    vecs[15] = '{1'b1, 1'b1, 20, 0, 0, 1, "moins_during_hold"};
    vecs[16] = '{1'b0, 1'b0, 12, 0, 0, 0, "release_both"};
    vecs[17] = '{1'b1, 1'b0, 20, 1, 0, 0, "plus_after_conflict"};
    vecs[18] = '{1'b0, 1'b0, 12, 0, 0, 0, "final_release"};

    // Button held through reset
    reset = 1'b1; btn_plus = 1'b1; btn_moins = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_plus", int'(plus), 0);
    check("reset_moins", int'(moins), 0);
    check("reset_conflit", int'(conflit), 0);
    check("reset_state", int'(dut.r_state), 0);
    check("reset_armed", int'(dut.r_armed_p), 0);
    reset = 1'b0;
    run_window(20, np, nm, nc);
    check("held_through_reset_plus", np, 0);
    check("held_debounced_high", int'(dut.r_d_p), 1);
    btn_plus = 1'b0;
    run_window(10, np, nm, nc);
    check("release_after_reset_plus", np, 0);

    // Exact press latency: pulse visible after edge 6
    btn_plus = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_k%0d", k), int'(plus), (k == 6) ? 1 : 0);
    end

    for (int i = 0; i < 19; i++) begin
      btn_plus  = vecs[i].p;
      btn_moins = vecs[i].m;
      run_window(vecs[i].cycles, np, nm, nc);
      check({vecs[i].name, "_plus"}, np, vecs[i].np);
      check({vecs[i].name, "_moins"}, nm, vecs[i].nm);
      check({vecs[i].name, "_conflit"}, nc, vecs[i].nc);
      if (i == 8) check("glitch_counter_zero", int'(dut.r_cnt_p), 0);
    end

    // Reset in the middle of a hold
    btn_plus = 1'b1;
    run_window(10, np, nm, nc);
    check("midhold_first_pulse", np, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midhold_reset_plus", int'(plus), 0);
    check("midhold_reset_plus_r", int'(plus_r), 0);
    check("midhold_reset_state", int'(dut.r_state), 0);
    reset = 1'b0;
    run_window(20, np, nm, nc);
    check("midhold_disarmed", np, 0);
    btn_plus = 1'b0;
    run_window(12, np, nm, nc);
    btn_plus = 1'b1;
    run_window(10, np, nm, nc);
    check("midhold_repress", np, 1);
    btn_plus = 1'b0;
    run_window(12, np, nm, nc);

    // Auto-repeat with period 8 versus no repeat
    btn_plus = 1'b1;
    np = 0; npr = 0;
    for (int k = 0; k < 46; k++) begin
      @(posedge clk);
      #1;
      np  += int'(plus);
      npr += int'(plus_r);
      check($sformatf("repeat_k%0d", k), int'(plus_r),
            ((k >= 6) && (((k - 6) % 8) == 0)) ? 1 : 0);
    end
    check("repeat_count_p8", npr, 5);
    check("repeat_count_p0", np, 1);
    btn_plus = 1'b0;
    run_window(12, np, nm, nc);

    check("mutual_exclusion", excl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
